gpio_in_conditioner: RTL and testbench
======================================

GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter WIDTH, default 12: number of raw board inputs conditioned, legal range 1..16. Bits [7:0] carry sw and bits [11:8] carry btn.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 250000: consecutive-cycle stability requirement, legal range 2..2^24.
REQ-004 Port clk_i  input  1  system clock; the only clock.
REQ-005 Port srst_n_i  input  1  reset, synchronous and active-low.
REQ-006 Port raw_i  input  WIDTH  asynchronous board inputs (switches, buttons).
REQ-007 Port clr_i  input  WIDTH  per-bit clear mask for sticky event flags, sampled each clock.
REQ-008 Port stable_o  output  WIDTH  debounced level per bit.
REQ-009 Port rise_o  output  WIDTH  one-cycle pulse when stable_o bit goes 0->1.
REQ-010 Port fall_o  output  WIDTH  one-cycle pulse when stable_o bit goes 1->0.
REQ-011 Port evt_o  output  WIDTH  sticky rise-event flags.
REQ-012 Port gpio_o  output  32  CPU gpio input word: [31:16] = zero-extended evt_o, [15:0] = zero-extended stable_o.

Function
REQ-013 Each bit SHALL pass through a SYNC_STAGES-deep flop chain; the last flop is the bit's sample s.
REQ-014 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES); bits are fully independent.
REQ-015 Per-bit state machine SHALL have two states: IDLE (s == stable) and COUNT (s != stable).
REQ-016 In IDLE, the counter SHALL be held at 0.
REQ-017 On any edge with s != stable, the counter SHALL increment.
REQ-018 On the DEBOUNCE_CYCLES-th consecutive such edge: stable SHALL load s, the counter SHALL return to 0, and the bit SHALL return to IDLE.
REQ-019 If s returns to the stable value before the count completes, the counter SHALL clear to 0 on that edge, with no output change (glitch rejection).
REQ-020 Latency from the first clock edge sampling a changed raw_i to the stable_o update SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-021 rise_o and fall_o SHALL be registered and asserted for exactly the one cycle following the stable_o update, never both on the same bit.
REQ-022 evt_o bit SHALL set on the edge on which the matching rise_o is registered high. It SHALL clear on an edge where the matching clr_i bit is 1. If set and clear coincide on the same edge, set SHALL win.
REQ-023 The counter SHALL never wrap; the terminal count is DEBOUNCE_CYCLES-1 followed by reload to 0.
REQ-024 gpio_o SHALL be purely combinational from registered stable_o and evt_o, adding no extra latency; bits above WIDTH SHALL read 0.

Reset
REQ-025 With srst_n_i low at a clock edge, all synchronizer flops, counters, stable_o, rise_o, fall_o and evt_o SHALL become 0.
REQ-026 Reset SHALL override every other function on the same edge, including mid-count and a pending rise pulse.
REQ-027 After reset release, an input held at 1 SHALL be treated as a fresh 0->1 change: it produces stable_o=1, rise_o and evt_o after SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-028 Outputs SHALL be defined (non-X) from the first edge with srst_n_i low.

Verification (bench uses WIDTH=12, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-029 Clean step: raw_i[0] 0->1 held -> stable_o[0]=1 exactly 6 edges later, rise_o[0] high 1 cycle, evt_o[0]=1, gpio_o=32'h0001_0001.
REQ-030 Glitch: raw_i[3] high for 3 cycles then low -> stable_o, rise_o and evt_o stay 0; internal counter back to 0.
REQ-031 Release: from stable_o[9]=1, raw_i[9] 1->0 held -> stable_o[9]=0 after 6 edges, fall_o[9] pulse, evt_o unchanged.
REQ-032 Sticky clear: evt_o[0]=1, clr_i=12'h001 one cycle -> evt_o[0]=0. Same clr on the rise_o[0] edge -> evt_o[0] stays 1.
REQ-033 Reset mid-operation: raw_i=12'hFFF, srst_n_i low at count 2 -> all outputs 0. On release, stable_o=12'hFFF and evt_o=12'hFFF after 6 edges.
REQ-034 Independence: raw_i[1] and raw_i[11] toggled 2 cycles apart -> each stable bit updates exactly 6 edges after its own input change.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
// Synchronizes, debounces and edge-detects a bank of raw board inputs
// (switches on bits [7:0], buttons on bits [11:8]) and presents the
// debounced levels plus sticky rise-event flags as a 32-bit CPU word.
// Every bit has its own synchronizer, counter and two-state debounce FSM.

module gpio_in_conditioner #(
    parameter int WIDTH           = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [WIDTH-1:0] raw_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] evt_o,
    output logic [31:0]      gpio_o
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits are enough
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sample;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    db_state_e        state_q [WIDTH];
    logic [WIDTH-1:0] load_hit;

    assign sample = sync_q[SYNC_STAGES-1];

    // Metastability chain: raw inputs shift through SYNC_STAGES flops per bit
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Flags the bits whose sample has disagreed long enough to be accepted this edge
    always_comb begin
        load_hit = '0;
        for (int b = 0; b < WIDTH; b++) begin
            load_hit[b] = (state_q[b] == COUNT) && (sample[b] != stable_o[b]) &&
                          (cnt_q[b] == CNT_LAST);
        end
    end

    // Per-bit debounce FSM: count disagreeing edges, accept the level on the last one
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            for (int b = 0; b < WIDTH; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
            end
            stable_o <= '0;
            rise_o   <= '0;
            fall_o   <= '0;
        end else begin
            rise_o <= '0;
            fall_o <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                case (state_q[b])
                    IDLE: begin
                        if (sample[b] != stable_o[b]) begin
                            cnt_q[b]   <= CNT_W'(1);
                            state_q[b] <= COUNT;
                        end else begin
                            cnt_q[b] <= '0;
                        end
                    end
                    COUNT: begin
                        if (sample[b] == stable_o[b]) begin
                            cnt_q[b]   <= '0;
                            state_q[b] <= IDLE;
                        end else if (load_hit[b]) begin
                            stable_o[b] <= sample[b];
                            rise_o[b]   <= sample[b];
                            fall_o[b]   <= ~sample[b];
                            cnt_q[b]    <= '0;
                            state_q[b]  <= IDLE;
                        end else begin
                            cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_q[b]   <= '0;
                        state_q[b] <= IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky rise flags: set alongside the rise pulse, cleared by mask, set wins
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            evt_o <= '0;
        end else begin
            evt_o <= (evt_o & ~clr_i) | (load_hit & sample);
        end
    end

    // CPU view: events in the upper half, levels in the lower half, unused bits zero
    always_comb begin
        gpio_o = '0;
        gpio_o[WIDTH-1:0]  = stable_o;
        gpio_o[16 +: WIDTH] = evt_o;
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner
// Directed bench for gpio_in_conditioner with a window-based reference model
// checked every clock plus hand-computed checkpoints for each scenario.

module tb_gpio_in_conditioner;

    localparam int W    = 12;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int HIST = SYNC + DB;

    logic         clk_i = 1'b0;
    logic         srst_n_i = 1'b0;
    logic [W-1:0] raw_i = '0;
    logic [W-1:0] clr_i = '0;
    logic [W-1:0] stable_o, rise_o, fall_o, evt_o;
    logic [31:0]  gpio_o;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state: raw history per edge and expected outputs
    logic [W-1:0] hist [HIST];
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_rise   = '0;
    logic [W-1:0] m_fall   = '0;
    logic [W-1:0] m_evt    = '0;

    gpio_in_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .raw_i    (raw_i),
        .clr_i    (clr_i),
        .stable_o (stable_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .evt_o    (evt_o),
        .gpio_o   (gpio_o)
    );

    // Free-running 10-unit clock
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] raw, input logic [W-1:0] clr);
        @(negedge clk_i);
        raw_i = raw;
        clr_i = clr;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // Model: a bit flips once its synchronized sample has opposed the held level
    // on each of the last DB edges; then compare every output after the edge
    always @(posedge clk_i) begin
        logic [W-1:0] raw_s, clr_s;
        logic         rst_n_s;
        logic         held;
        raw_s   = raw_i;
        clr_s   = clr_i;
        rst_n_s = srst_n_i;
        if (!rst_n_s) begin
            for (int j = 0; j < HIST; j++) hist[j] = '0;
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_evt    = '0;
        end else begin
            for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = raw_s;
            m_rise  = '0;
            m_fall  = '0;
            for (int b = 0; b < W; b++) begin
                held = 1'b1;
                for (int j = SYNC; j < HIST; j++) begin
                    if (hist[j][b] == m_stable[b]) held = 1'b0;
                end
                if (held) begin
                    m_stable[b] = ~m_stable[b];
                    if (m_stable[b]) m_rise[b] = 1'b1;
                    else             m_fall[b] = 1'b1;
                end
            end
            m_evt = (m_evt & ~clr_s) | m_rise;
        end
        #1;
        checkOutput("model_stable", 32'(stable_o), 32'(m_stable));
        checkOutput("model_rise",   32'(rise_o),   32'(m_rise));
        checkOutput("model_fall",   32'(fall_o),   32'(m_fall));
        checkOutput("model_evt",    32'(evt_o),    32'(m_evt));
        checkOutput("model_gpio",   gpio_o,        {4'h0, m_evt, 4'h0, m_stable});
    end

    // Directed scenarios with literal checkpoints
    initial begin
        for (int j = 0; j < HIST; j++) hist[j] = '0;

        // Reset state
        waitEdges(3);
        checkOutput("reset_stable", 32'(stable_o), 32'h0);
        checkOutput("reset_evt",    32'(evt_o),    32'h0);
        checkOutput("reset_gpio",   gpio_o,        32'h0);
        @(negedge clk_i);
        srst_n_i = 1'b1;
        waitEdges(2);

        // Clean step on bit 0
        applyStimulus(12'h001, 12'h000);
        waitEdges(5);
        checkOutput("step_edge5_stable", 32'(stable_o), 32'h0);
        waitEdges(1);
        checkOutput("step_edge6_stable", 32'(stable_o), 32'h001);
        checkOutput("step_edge6_rise",   32'(rise_o),   32'h001);
        checkOutput("step_edge6_gpio",   gpio_o,        32'h0001_0001);
        waitEdges(1);
        checkOutput("step_edge7_rise",   32'(rise_o),   32'h0);

        // Sticky clear
        applyStimulus(12'h001, 12'h001);
        waitEdges(1);
        checkOutput("clear_evt",  32'(evt_o), 32'h0);
        checkOutput("clear_gpio", gpio_o,     32'h0000_0001);
        applyStimulus(12'h001, 12'h000);

        // Glitch on bit 3: three cycles high is one short of acceptance
        applyStimulus(12'h009, 12'h000);
        applyStimulus(12'h009, 12'h000);
        applyStimulus(12'h009, 12'h000);
        applyStimulus(12'h001, 12'h000);
        waitEdges(8);
        checkOutput("glitch_stable", 32'(stable_o), 32'h001);
        checkOutput("glitch_evt",    32'(evt_o),    32'h0);

        // Raise bit 9, then release it
        applyStimulus(12'h201, 12'h000);
        waitEdges(7);
        checkOutput("b9_set_stable", 32'(stable_o), 32'h201);
        checkOutput("b9_set_evt",    32'(evt_o),    32'h200);
        applyStimulus(12'h001, 12'h000);
        waitEdges(5);
        checkOutput("release_edge5_stable", 32'(stable_o), 32'h201);
        waitEdges(1);
        checkOutput("release_stable", 32'(stable_o), 32'h001);
        checkOutput("release_fall",   32'(fall_o),   32'h200);
        checkOutput("release_evt",    32'(evt_o),    32'h200);

        // Set and clear on the same edge: set wins
        applyStimulus(12'h000, 12'hFFF);
        applyStimulus(12'h000, 12'h000);
        waitEdges(7);
        checkOutput("low_stable", 32'(stable_o), 32'h0);
        checkOutput("low_evt",    32'(evt_o),    32'h0);
        applyStimulus(12'h001, 12'h000);
        for (int i = 0; i < 4; i++) applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h001, 12'h001);
        waitEdges(1);
        checkOutput("coincide_rise", 32'(rise_o), 32'h001);
        checkOutput("coincide_evt",  32'(evt_o),  32'h001);
        applyStimulus(12'h001, 12'h000);
        waitEdges(2);

        // Independence: bit 1 then bit 11 two cycles later
        applyStimulus(12'h003, 12'h000);
        applyStimulus(12'h003, 12'h000);
        applyStimulus(12'h803, 12'h000);
        waitEdges(3);
        checkOutput("indep_edge5_stable", 32'(stable_o), 32'h001);
        waitEdges(1);
        checkOutput("indep_edge6_stable", 32'(stable_o), 32'h003);
        checkOutput("indep_edge6_rise",   32'(rise_o),   32'h002);
        waitEdges(1);
        checkOutput("indep_edge7_stable", 32'(stable_o), 32'h003);
        waitEdges(1);
        checkOutput("indep_edge8_stable", 32'(stable_o), 32'h803);
        checkOutput("indep_edge8_rise",   32'(rise_o),   32'h800);
        checkOutput("indep_edge8_gpio",   gpio_o,        32'h0803_0803);

        // Reset mid-count with all inputs high, then fresh acceptance
        applyStimulus(12'hFFF, 12'h000);
        repeat (4) @(negedge clk_i);
        srst_n_i = 1'b0;
        waitEdges(1);
        checkOutput("midreset_stable", 32'(stable_o), 32'h0);
        checkOutput("midreset_rise",   32'(rise_o),   32'h0);
        checkOutput("midreset_gpio",   gpio_o,        32'h0);
        waitEdges(2);
        @(negedge clk_i);
        srst_n_i = 1'b1;
        waitEdges(5);
        checkOutput("post_reset_edge5_stable", 32'(stable_o), 32'h0);
        waitEdges(1);
        checkOutput("post_reset_stable", 32'(stable_o), 32'hFFF);
        checkOutput("post_reset_rise",   32'(rise_o),   32'hFFF);
        checkOutput("post_reset_gpio",   gpio_o,        32'h0FFF_0FFF);

        waitEdges(2);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
